// File: rtl/cond_unit.sv
`default_nettype none
// ============================================================================
// cond_unit : ARM-style condition check, NZCV flag register, write-enable
//             gating and optional Thumb IT-block tracking (COND_UNIT_IT_EN).
// Revision  : 1.0
// ============================================================================
module cond_unit #(
  parameter int FLAG_GRPS = 2,
  parameter int IT_MASK_W = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [3:0]           Cond,
  input  logic [3:0]           ALUFlags,
  input  logic [FLAG_GRPS-1:0] FlagW,
  input  logic                 PCS,
  input  logic                 NextPC,
  input  logic                 RegW,
  input  logic                 MemW,
  input  logic                 InstrAdv,
  input  logic                 ITStart,
  input  logic [3:0]           ITCond,
  input  logic [IT_MASK_W-1:0] ITMask,
  output logic                 PCWrite,
  output logic                 RegWrite,
  output logic                 MemWrite,
  output logic [3:0]           Flags,
  output logic                 CondEx,
  output logic                 InIT,
  output logic                 ITErr
);

  logic [3:0] flags_q, flags_d;
  logic [3:0] flag_grp_we;
  logic [3:0] flag_wr;
  logic [3:0] eff_cond;
  logic       cond_ex;
  logic       condexr_q;
  logic       in_it;
  logic       it_err;

  generate
    if (FLAG_GRPS == 1) begin : g_grp1
      assign flag_grp_we = {4{FlagW[0]}};
    end else if (FLAG_GRPS == 2) begin : g_grp2
      assign flag_grp_we = {FlagW[1], FlagW[1], FlagW[0], FlagW[0]};
    end else begin : g_grp4
      assign flag_grp_we = FlagW[3:0];
    end
  endgenerate

`ifdef COND_UNIT_IT_EN
  localparam int ST_W = IT_MASK_W + 4;

  logic [ST_W-1:0] it_state_q, it_state_d;
  logic            it_err_q, it_err_d;

  assign in_it    = (it_state_q[IT_MASK_W-1:0] != '0);
  assign eff_cond = in_it ? it_state_q[ST_W-1:IT_MASK_W] : Cond;
  assign it_err   = it_err_q;

  // An illegal IT start leaves the current block untouched and only raises ITErr.
  always_comb begin
    it_state_d = it_state_q;
    it_err_d   = 1'b0;
    if (InstrAdv) begin
      if (ITStart && ((ITMask == '0) || in_it)) begin
        it_err_d = 1'b1;
      end else if (in_it) begin
        if (it_state_q[IT_MASK_W-2:0] == '0) begin
          it_state_d = '0;
        end else begin
          it_state_d[IT_MASK_W:0] = {it_state_q[IT_MASK_W-1:0], 1'b0};
        end
      end else if (ITStart) begin
        it_state_d = {ITCond, ITMask};
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      it_state_q <= '0;
      it_err_q   <= 1'b0;
    end else begin
      it_state_q <= it_state_d;
      it_err_q   <= it_err_d;
    end
  end
`else
  logic unused_it;

  assign unused_it = ^{InstrAdv, ITStart, ITCond, ITMask};
  assign in_it     = 1'b0;
  assign it_err    = 1'b0;
  assign eff_cond  = Cond;
`endif

  always_comb begin
    case (eff_cond)
      4'b0000: cond_ex = flags_q[2];
      4'b0001: cond_ex = ~flags_q[2];
      4'b0010: cond_ex = flags_q[1];
      4'b0011: cond_ex = ~flags_q[1];
      4'b0100: cond_ex = flags_q[3];
      4'b0101: cond_ex = ~flags_q[3];
      4'b0110: cond_ex = flags_q[0];
      4'b0111: cond_ex = ~flags_q[0];
      4'b1000: cond_ex = flags_q[1] & ~flags_q[2];
      4'b1001: cond_ex = ~flags_q[1] | flags_q[2];
      4'b1010: cond_ex = (flags_q[3] == flags_q[0]);
      4'b1011: cond_ex = (flags_q[3] != flags_q[0]);
      4'b1100: cond_ex = ~flags_q[2] & (flags_q[3] == flags_q[0]);
      4'b1101: cond_ex = flags_q[2] | (flags_q[3] != flags_q[0]);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  assign flag_wr = flag_grp_we & {4{cond_ex}};
  assign flags_d = (flag_wr & ALUFlags) | (~flag_wr & flags_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flags_q   <= 4'b0000;
      condexr_q <= 1'b0;
    end else begin
      flags_q   <= flags_d;
      condexr_q <= cond_ex;
    end
  end

  assign Flags    = flags_q;
  assign CondEx   = cond_ex;
  assign InIT     = in_it;
  assign ITErr    = it_err;
  assign RegWrite = RegW & condexr_q;
  assign MemWrite = MemW & condexr_q;
  assign PCWrite  = (PCS & condexr_q) | NextPC;

endmodule
`default_nettype wire

// File: tb/tb_cond_unit.sv
`default_nettype none
// ============================================================================
// tb_cond_unit : self-checking bench for cond_unit (FLAG_GRPS=2 and =4 copies).
// Revision     : 1.0
// ============================================================================
module tb_cond_unit;
  localparam int IT_MASK_W = 4;
`ifdef COND_UNIT_IT_EN
  localparam bit IT_EN = 1'b1;
`else
  localparam bit IT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 reset;
  logic [3:0]           Cond, ALUFlags, ITCond;
  logic [1:0]           FlagW2;
  logic [3:0]           FlagW4;
  logic                 PCS, NextPC, RegW, MemW, InstrAdv, ITStart;
  logic [IT_MASK_W-1:0] ITMask;

  logic [3:0] flags_o [2];
  logic [1:0] pcw_o, rw_o, mw_o, cex_o, init_o, err_o;

  cond_unit #(.FLAG_GRPS(2), .IT_MASK_W(IT_MASK_W)) dut2 (
    .clk(clk), .reset(reset), .Cond(Cond), .ALUFlags(ALUFlags), .FlagW(FlagW2),
    .PCS(PCS), .NextPC(NextPC), .RegW(RegW), .MemW(MemW), .InstrAdv(InstrAdv),
    .ITStart(ITStart), .ITCond(ITCond), .ITMask(ITMask),
    .PCWrite(pcw_o[0]), .RegWrite(rw_o[0]), .MemWrite(mw_o[0]), .Flags(flags_o[0]),
    .CondEx(cex_o[0]), .InIT(init_o[0]), .ITErr(err_o[0]));

  cond_unit #(.FLAG_GRPS(4), .IT_MASK_W(IT_MASK_W)) dut4 (
    .clk(clk), .reset(reset), .Cond(Cond), .ALUFlags(ALUFlags), .FlagW(FlagW4),
    .PCS(PCS), .NextPC(NextPC), .RegW(RegW), .MemW(MemW), .InstrAdv(InstrAdv),
    .ITStart(ITStart), .ITCond(ITCond), .ITMask(ITMask),
    .PCWrite(pcw_o[1]), .RegWrite(rw_o[1]), .MemWrite(mw_o[1]), .Flags(flags_o[1]),
    .CondEx(cex_o[1]), .InIT(init_o[1]), .ITErr(err_o[1]));

  int nvec = 0;
  int nbad = 0;

  // Reference model: architectural flags, registered condition, and the IT
  // block held as the list of conditions still to be consumed.
  logic [3:0] m_flags [2];
  logic [1:0] m_cexr;
  logic       m_err;
  logic [3:0] itq [$];

  function automatic logic cond_true(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v, base;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy && !z;
      3'd5: base = (n == v);
      3'd6: base = (n == v) && !z;
      default: return (c == 4'b1110);
    endcase
    return base ^ c[0];
  endfunction

  function automatic logic [3:0] grp_we(input int d);
    if (d == 0) return {FlagW2[1], FlagW2[1], FlagW2[0], FlagW2[0]};
    return FlagW4;
  endfunction

  function automatic logic [3:0] eff_cond();
    return (itq.size() != 0) ? itq[0] : Cond;
  endfunction

  function automatic logic [9:0] expected(input int d);
    logic cx;
    cx = cond_true(eff_cond(), m_flags[d]);
    return {m_flags[d], cx, (PCS & m_cexr[d]) | NextPC, RegW & m_cexr[d],
            MemW & m_cexr[d], itq.size() != 0, m_err};
  endfunction

  function automatic logic [9:0] act(input int d);
    return {flags_o[d], cex_o[d], pcw_o[d], rw_o[d], mw_o[d], init_o[d], err_o[d]};
  endfunction

  task automatic model_reset();
    m_flags[0] = 4'b0; m_flags[1] = 4'b0;
    m_cexr = 2'b0; m_err = 1'b0;
    itq.delete();
  endtask

  task automatic model_edge();
    logic [3:0] ec, we;
    logic       cx;
    int         low, len;
    ec = eff_cond();
    for (int d = 0; d < 2; d++) begin
      cx = cond_true(ec, m_flags[d]);
      we = grp_we(d) & {4{cx}};
      m_flags[d] = (m_flags[d] & ~we) | (ALUFlags & we);
      m_cexr[d] = cx;
    end
    if (IT_EN) begin
      m_err = 1'b0;
      if (InstrAdv && ITStart && (ITMask == '0 || itq.size() != 0)) begin
        m_err = 1'b1;
      end else if (InstrAdv && itq.size() != 0) begin
        void'(itq.pop_front());
      end else if (InstrAdv && ITStart) begin
        low = 0;
        for (int i = IT_MASK_W - 1; i >= 0; i--) if (ITMask[i]) low = i;
        len = IT_MASK_W - low;
        itq.push_back(ITCond);
        for (int k = 1; k < len; k++) itq.push_back({ITCond[3:1], ITMask[IT_MASK_W-k]});
      end
    end
  endtask

  task automatic check(input string name, input logic [9:0] a, input logic [9:0] e);
    nvec++;
    if (a !== e) begin
      nbad++;
      $display("FAIL %s: got {F,CondEx,PCW,RegW,MemW,InIT,ITErr}=%b, expected %b", name, a, e);
    end
  endtask

  task automatic clear_inputs();
    Cond = 4'b1110; ALUFlags = 4'b0; FlagW2 = 2'b0; FlagW4 = 4'b0;
    PCS = 1'b0; NextPC = 1'b0; RegW = 1'b0; MemW = 1'b0;
    InstrAdv = 1'b0; ITStart = 1'b0; ITCond = 4'b0; ITMask = '0;
  endtask

  // Asserts reset on a falling edge; the next driving task releases it.
  task automatic do_reset(input string nm);
    @(negedge clk);
    clear_inputs();
    reset = 1'b0;
    PCS = 1'b1; NextPC = 1'b1; RegW = 1'b1; MemW = 1'b1;
    model_reset();
    #1;
    check({nm, "_d2"}, act(0), expected(0));
    check({nm, "_d4"}, act(1), expected(1));
  endtask

  typedef struct {
    logic [3:0] cond, alu;
    logic [1:0] fw2;
    logic [3:0] fw4;
    logic       pcs, npc, regw, memw;
    logic [3:0] f2, f4;
    logic       cex, pcw, rw, mw;
  } vec_t;

  vec_t tbl [12];

  task automatic it_cyc(input string nm, input logic adv, input logic st,
                        input logic [3:0] itc, input logic [IT_MASK_W-1:0] itm,
                        input logic e_init, input logic e_cex, input logic e_err);
    @(negedge clk);
    clear_inputs();
    reset = 1'b1;
    InstrAdv = adv; ITStart = st; ITCond = itc; ITMask = itm;
    #1;
    check(nm, {7'b0, init_o[0], cex_o[0], err_o[0]}, {7'b0, e_init, e_cex, e_err});
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    clear_inputs();
    //           cond     alu      fw2    fw4      pcs   npc   regw  memw  f2       f4       cex   pcw   rw    mw
    tbl[0]  = '{4'b1110, 4'b0100, 2'b11, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{4'b0001, 4'b1000, 2'b11, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0100, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{4'b0000, 4'b0000, 2'b00, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b1, 4'b0100, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{4'b1111, 4'b0000, 2'b00, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b1, 4'b0100, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[4]  = '{4'b1111, 4'b0000, 2'b00, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b1, 4'b0100, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{4'b1110, 4'b0000, 2'b11, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0100, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{4'b1110, 4'b1111, 2'b01, 4'b1000, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{4'b1000, 4'b0000, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0011, 4'b1000, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{4'b1011, 4'b0000, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0011, 4'b1000, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[9]  = '{4'b1100, 4'b0000, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0011, 4'b1000, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[10] = '{4'b0110, 4'b0000, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0011, 4'b1000, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{4'b0011, 4'b0000, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0011, 4'b1000, 1'b0, 1'b0, 1'b1, 1'b0};

    do_reset("reset");
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      clear_inputs();
      reset = 1'b1;
      Cond = tbl[i].cond; ALUFlags = tbl[i].alu; FlagW2 = tbl[i].fw2; FlagW4 = tbl[i].fw4;
      PCS = tbl[i].pcs; NextPC = tbl[i].npc; RegW = tbl[i].regw; MemW = tbl[i].memw;
      #1;
      check($sformatf("tbl%0d_d2", i), act(0),
            {tbl[i].f2, tbl[i].cex, tbl[i].pcw, tbl[i].rw, tbl[i].mw, 2'b00});
      check($sformatf("tbl%0d_f4", i), {6'b0, flags_o[1]}, {6'b0, tbl[i].f4});
    end

    // Hand sequences, flags cleared so Z=0 (EQ false, NE true).
    do_reset("reset_it");
`ifdef COND_UNIT_IT_EN
    it_cyc("it_start",   1'b1, 1'b1, 4'b0000, 4'b1010, 1'b0, 1'b1, 1'b0);
    it_cyc("it_i1_eq",   1'b1, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0);
    it_cyc("it_i2_ne",   1'b1, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0);
    it_cyc("it_i3_eq",   1'b1, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0);
    it_cyc("it_done",    1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0);
    it_cyc("err0_req",   1'b1, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0);
    it_cyc("err0_pulse", 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b1);
    it_cyc("err0_clear", 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0);
    it_cyc("err1_start", 1'b1, 1'b1, 4'b0000, 4'b1010, 1'b0, 1'b1, 1'b0);
    it_cyc("err1_i1",    1'b1, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0);
    it_cyc("err1_req",   1'b1, 1'b1, 4'b1110, 4'b1000, 1'b1, 1'b1, 1'b0);
    it_cyc("err1_pulse", 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b1, 1'b1);
    it_cyc("err1_i2_ne", 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0);
    it_cyc("err1_i3_eq", 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0);
    do_reset("reset_mid_pre");
    @(negedge clk);
    clear_inputs();
    reset = 1'b1; ALUFlags = 4'b0100; FlagW2 = 2'b11; FlagW4 = 4'b1111;
    it_cyc("rst_start",  1'b1, 1'b1, 4'b0000, 4'b0100, 1'b0, 1'b1, 1'b0);
    it_cyc("rst_i1_eq",  1'b1, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_mid_d2", act(0) & 10'b1111_00_0_0_1_1, 10'b0);
    check("rst_mid_d4", act(1) & 10'b1111_00_0_0_1_1, 10'b0);
    it_cyc("rst_after",  1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0);
`else
    it_cyc("noit_start", 1'b1, 1'b1, 4'b0000, 4'b1010, 1'b0, 1'b1, 1'b0);
    it_cyc("noit_adv",   1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0);
    it_cyc("noit_err",   1'b1, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0);
    it_cyc("noit_after", 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0);
`endif

    // Randomized run against the reference model, with occasional resets.
    do_reset("reset_rnd");
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      reset    = ($urandom_range(0, 49) != 0);
      Cond     = 4'($urandom);
      ALUFlags = 4'($urandom);
      FlagW2   = 2'($urandom);
      FlagW4   = 4'($urandom);
      PCS      = 1'($urandom); NextPC = 1'($urandom);
      RegW     = 1'($urandom); MemW   = 1'($urandom);
      InstrAdv = ($urandom_range(0, 2) == 0);
      ITStart  = ($urandom_range(0, 3) == 0);
      ITCond   = 4'($urandom);
      ITMask   = ($urandom_range(0, 5) == 0) ? '0 : IT_MASK_W'($urandom);
      if (!reset) model_reset();
      #1;
      check($sformatf("rnd%0d_d2", i), act(0), expected(0));
      check($sformatf("rnd%0d_d4", i), act(1), expected(1));
      @(posedge clk);
      if (reset) model_edge();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cond_unit.md
COND_UNIT -- requirements
Module: cond_unit

Interface
REQ-001 SHALL have parameter FLAG_GRPS, default 2, meaning the number of independently writable flag groups (legal values 1, 2, 4).
REQ-002 SHALL have parameter IT_MASK_W, default 4, meaning the IT mask width, which equals the maximum number of predicated instructions per IT block.
REQ-003 SHALL have these ports, one per line (name, direction, width, meaning):
  clk  in  1  sole clock, rising edge
  reset  in  1  asynchronous, active-low reset
  Cond  in  4  condition field of the current instruction
  ALUFlags  in  4  {N,Z,C,V} from the ALU
  FlagW  in  FLAG_GRPS  per-group flag write request
  PCS, NextPC, RegW, MemW  in  1 each  raw write requests from the main FSM
  InstrAdv  in  1  single-cycle pulse marking retirement of the current instruction
  ITStart  in  1  current instruction is an IT instruction (sampled with InstrAdv)
  ITCond  in  4  firstcond of the IT instruction
  ITMask  in  IT_MASK_W  mask of the IT instruction
  PCWrite, RegWrite, MemWrite  out  1 each  gated write enables
  Flags  out  4  architectural {N,Z,C,V}
  CondEx  out  1  combinational condition result, current cycle
  InIT  out  1  IT block active
  ITErr  out  1  one-cycle pulse on an illegal IT start

Function
REQ-004 Effective condition SHALL be ITState[IT_MASK_W+3:IT_MASK_W] when InIT=1, else Cond.
REQ-005 CondEx SHALL follow ARM encoding 0000 EQ through 1101 LE, 1110 AL=1; 1111 SHALL evaluate to 0.
REQ-006 Group mapping: FLAG_GRPS=1 writes all of NZCV; FLAG_GRPS=2 uses FlagW[1] for NZ and FlagW[0] for CV; FLAG_GRPS=4 uses FlagW[3:0] for N,Z,C,V respectively.
REQ-007 A group SHALL load ALUFlags on the clock edge when its FlagW bit AND CondEx are both 1.
REQ-008 CondExr SHALL be CondEx registered every cycle (one-cycle latency).
REQ-009 Enables: RegWrite = RegW & CondExr; MemWrite = MemW & CondExr; PCWrite = (PCS & CondExr) | NextPC.
REQ-010 ITState SHALL be a register of IT_MASK_W+4 bits; InIT SHALL equal (ITState[IT_MASK_W-1:0] != 0).
REQ-011 IT start: when InIT=0, InstrAdv=1, ITStart=1 and ITMask!=0, ITState SHALL load {ITCond, ITMask} on the next edge.
REQ-012 Advance: when InIT=1 and InstrAdv=1, ITState SHALL clear to 0 if ITState[IT_MASK_W-2:0]==0; otherwise ITState[IT_MASK_W:0] SHALL shift left one bit, with 0 shifted in and the upper condition bits held.
REQ-013 Block length SHALL be IT_MASK_W minus the index of the lowest set mask bit; the last predicated instruction sees InIT=1 and retires with InIT falling on that edge.
REQ-014 ITErr SHALL pulse for one cycle, with ITState unchanged, when ITStart & InstrAdv occurs with ITMask==0 or with InIT=1.
REQ-015 ITStart without InstrAdv SHALL be ignored.
REQ-016 With InstrAdv=0, ITState SHALL hold.

Reset
REQ-017 reset=0 SHALL asynchronously force Flags=0000, CondExr=0, ITState=0 and ITErr=0, which gives InIT=0, RegWrite=0, MemWrite=0 and PCWrite=NextPC.
REQ-018 Reset asserted mid-IT-block SHALL abandon the block; after release, conditions come from Cond.

Configuration
REQ-019 With macro COND_UNIT_IT_EN defined, REQ-004 and REQ-010 through REQ-016 SHALL be implemented.
REQ-020 Without COND_UNIT_IT_EN, the IT ports SHALL remain present and be ignored, InIT and ITErr SHALL be tied to 0, no ITState flops SHALL be built, and the effective condition SHALL be Cond.

Verification
REQ-021 Flag gating: reset, ALUFlags=0100, FlagW=11, Cond=1110, one edge -> Flags=0100; then Cond=0001 (NE), ALUFlags=1000 -> Flags stay 0100.
REQ-022 Group split: FLAG_GRPS=2, FlagW=01, ALUFlags=1111, Cond=1110 -> Flags=0011 from 0000; with FLAG_GRPS=4, FlagW=1000 -> Flags=1000.
REQ-023 Latency: Cond=0000, Z=1, RegW=MemW=PCS=1 -> all three enables 0 in the CondEx cycle and 1 exactly one cycle later; NextPC=1 -> PCWrite=1 regardless.
REQ-024 IT block (COND_UNIT_IT_EN): ITCond=0000, ITMask=1010 with InstrAdv -> next 3 instructions use EQ, NE, EQ; InIT stays high for 3 InstrAdv pulses, then drops.
REQ-025 Errors: ITMask=0000 -> ITErr pulses once with InIT=0; ITStart during an active block -> ITErr pulses once and the block continues unchanged.
REQ-026 Reset mid-block: assert reset after the 1st predicated instruction -> InIT=0 and Flags=0000 immediately; without COND_UNIT_IT_EN, any IT stimulus -> InIT=0 and ITErr=0.
